// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer for the Tomasulo core.
// Allocates entries in program order, captures per-FU results from the
// result buses, republishes completed values to the reservation stations,
// and retires one entry per cycle to the register file.
// Optional feature macro: ROB_FLUSH_EN -- when defined, retiring a taken
// branch flushes every entry and pulses flush/reset_bus for one cycle.
module reorder_buffer #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   RB_SIZE   = 8,
    parameter int                   RB_INDEX  = 4,
    parameter logic [RB_INDEX-1:0]  NULL      = {RB_INDEX{1'b1}},
    parameter int                   FU_NUM    = 4,
    parameter int                   REG_INDEX = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_req,
    input  logic [REG_INDEX-1:0]          alloc_dest,
    input  logic                          alloc_is_branch,
    output logic                          alloc_ready,
    output logic [RB_INDEX-1:0]           alloc_index,
    input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    input  logic [FU_NUM-1:0]             valid_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
    output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
    output logic [RB_SIZE-1:0]            CDB_data_valid,
    output logic [FU_NUM-1:0]             reset_bus,
    output logic                          commit_valid,
    output logic [REG_INDEX-1:0]          commit_reg,
    output logic [WORD_SIZE-1:0]          commit_data,
    output logic                          branch_valid,
    output logic                          branch_taken,
    output logic                          flush
);

    localparam logic [RB_INDEX-1:0] LAST_IDX = RB_INDEX'(RB_SIZE - 1);
    localparam logic [RB_INDEX-1:0] FULL_CNT = RB_INDEX'(RB_SIZE);
    localparam logic [RB_INDEX-1:0] ONE_IDX  = {{(RB_INDEX-1){1'b0}}, 1'b1};

    // Pointer advance with wrap from the last entry back to 0.
    function automatic logic [RB_INDEX-1:0] next_ptr(input logic [RB_INDEX-1:0] p);
        return (p == LAST_IDX) ? {RB_INDEX{1'b0}} : (p + ONE_IDX);
    endfunction

    // Entry state
    logic [RB_SIZE-1:0]                  busy_q, busy_d;
    logic [RB_SIZE-1:0]                  done_q, done_d;
    logic [RB_SIZE-1:0]                  is_br_q, is_br_d;
    logic [RB_SIZE-1:0][REG_INDEX-1:0]   dest_q, dest_d;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0]   value_q, value_d;
    logic [RB_INDEX-1:0]                 head_q, head_d;
    logic [RB_INDEX-1:0]                 tail_q, tail_d;
    logic [RB_INDEX-1:0]                 count_q, count_d;

    // Registered outputs
    logic [RB_SIZE-1:0]                  cdb_valid_q;
    logic [RB_SIZE-1:0][WORD_SIZE-1:0]   cdb_data_q;
    logic                                commit_valid_q, commit_valid_d;
    logic [REG_INDEX-1:0]                commit_reg_q, commit_reg_d;
    logic [WORD_SIZE-1:0]                commit_data_q, commit_data_d;
    logic                                branch_valid_q, branch_valid_d;
    logic                                branch_taken_q, branch_taken_d;
    logic                                flush_q, flush_d;
    logic [FU_NUM-1:0]                   reset_bus_q, reset_bus_d;

    // Combinational helpers
    logic [RB_SIZE-1:0]                  head_mask_s, tail_mask_s, wb_hit_s;
    logic                                wb_take_s;
    logic                                head_busy_s, head_done_s, head_br_s;
    logic [REG_INDEX-1:0]                head_dest_s;
    logic [WORD_SIZE-1:0]                head_val_s;
    logic                                alloc_ready_s, alloc_s, commit_s;

    assign alloc_ready    = alloc_ready_s;
    assign alloc_index    = tail_q;
    assign CDB_data_data  = cdb_data_q;
    assign CDB_data_valid = cdb_valid_q;
    assign reset_bus      = reset_bus_q;
    assign commit_valid   = commit_valid_q;
    assign commit_reg     = commit_reg_q;
    assign commit_data    = commit_data_q;
    assign branch_valid   = branch_valid_q;
    assign branch_taken   = branch_taken_q;
    assign flush          = flush_q;

    // Next-state: writeback capture, head retirement, allocation, flush.
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        is_br_d   = is_br_q;
        dest_d    = dest_q;
        value_d   = value_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wb_hit_s  = {RB_SIZE{1'b0}};
        wb_take_s = 1'b0;
        head_dest_s = {REG_INDEX{1'b0}};
        head_val_s  = {WORD_SIZE{1'b0}};

        for (int i = 0; i < RB_SIZE; i++) begin
            head_mask_s[i] = (head_q == RB_INDEX'(i));
            tail_mask_s[i] = (tail_q == RB_INDEX'(i));
        end

        // Writeback: FUs are scanned lowest first, so the lowest FU naming an
        // entry claims it. Matching the tag against an existing index also
        // rejects out-of-range tags without truncating them. Only entries that
        // are already busy (registered) and not done accept a result.
        for (int i = 0; i < RB_SIZE; i++) begin
            for (int f = 0; f < FU_NUM; f++) begin
                wb_take_s = valid_bus[f] && !wb_hit_s[i] && busy_q[i] && !done_q[i] &&
                            (RB_index_bus[f*RB_INDEX +: RB_INDEX] != NULL) &&
                            (RB_index_bus[f*RB_INDEX +: RB_INDEX] == RB_INDEX'(i));
                wb_hit_s[i] = wb_hit_s[i] | wb_take_s;
                done_d[i]   = done_d[i]   | wb_take_s;
                value_d[i]  = wb_take_s ? data_bus[f*WORD_SIZE +: WORD_SIZE] : value_d[i];
            end
        end

        // Head entry view; commit decisions use registered done only.
        head_busy_s = |(busy_q  & head_mask_s);
        head_done_s = |(done_q  & head_mask_s);
        head_br_s   = |(is_br_q & head_mask_s);
        for (int i = 0; i < RB_SIZE; i++) begin
            head_dest_s = head_dest_s | ({REG_INDEX{head_mask_s[i]}} & dest_q[i]);
            head_val_s  = head_val_s  | ({WORD_SIZE{head_mask_s[i]}} & value_q[i]);
        end
        commit_s = head_busy_s && head_done_s;

        busy_d = busy_d & ~({RB_SIZE{commit_s}} & head_mask_s);
        done_d = done_d & ~({RB_SIZE{commit_s}} & head_mask_s);
        head_d = commit_s ? next_ptr(head_q) : head_q;

        // Allocation: a full buffer stays blocked even if the head retires now.
        alloc_ready_s = (count_q < FULL_CNT) && !flush_q;
        alloc_s       = alloc_req && alloc_ready_s;
        busy_d = busy_d |  ({RB_SIZE{alloc_s}} & tail_mask_s);
        done_d = done_d & ~({RB_SIZE{alloc_s}} & tail_mask_s);
        for (int i = 0; i < RB_SIZE; i++) begin
            dest_d[i]  = (alloc_s && tail_mask_s[i]) ? alloc_dest      : dest_d[i];
            is_br_d[i] = (alloc_s && tail_mask_s[i]) ? alloc_is_branch : is_br_d[i];
        end
        tail_d  = alloc_s ? next_ptr(tail_q) : tail_q;
        count_d = count_q + (alloc_s ? ONE_IDX : {RB_INDEX{1'b0}})
                          - (commit_s ? ONE_IDX : {RB_INDEX{1'b0}});

        // Retirement strobes.
        commit_valid_d = commit_s && !head_br_s;
        commit_reg_d   = commit_valid_d ? head_dest_s : {REG_INDEX{1'b0}};
        commit_data_d  = commit_valid_d ? head_val_s  : {WORD_SIZE{1'b0}};
        branch_valid_d = commit_s && head_br_s;
        branch_taken_d = branch_valid_d && head_val_s[0];

`ifdef ROB_FLUSH_EN
        flush_d = branch_taken_d;
`else
        flush_d = 1'b0;
`endif
        reset_bus_d = {FU_NUM{flush_d}};

        // A taken branch discards everything else happening on this edge.
        busy_d  = flush_d ? {RB_SIZE{1'b0}}  : busy_d;
        done_d  = flush_d ? {RB_SIZE{1'b0}}  : done_d;
        head_d  = flush_d ? {RB_INDEX{1'b0}} : head_d;
        tail_d  = flush_d ? {RB_INDEX{1'b0}} : tail_d;
        count_d = flush_d ? {RB_INDEX{1'b0}} : count_d;
    end

    // State and output registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q         <= {RB_SIZE{1'b0}};
            done_q         <= {RB_SIZE{1'b0}};
            is_br_q        <= {RB_SIZE{1'b0}};
            dest_q         <= '0;
            value_q        <= '0;
            head_q         <= {RB_INDEX{1'b0}};
            tail_q         <= {RB_INDEX{1'b0}};
            count_q        <= {RB_INDEX{1'b0}};
            cdb_valid_q    <= {RB_SIZE{1'b0}};
            cdb_data_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_q   <= {REG_INDEX{1'b0}};
            commit_data_q  <= {WORD_SIZE{1'b0}};
            branch_valid_q <= 1'b0;
            branch_taken_q <= 1'b0;
            flush_q        <= 1'b0;
            reset_bus_q    <= {FU_NUM{1'b1}};
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            is_br_q        <= is_br_d;
            dest_q         <= dest_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cdb_valid_q    <= busy_d & done_d;
            cdb_data_q     <= value_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_q   <= commit_reg_d;
            commit_data_q  <= commit_data_d;
            branch_valid_q <= branch_valid_d;
            branch_taken_q <= branch_taken_d;
            flush_q        <= flush_d;
            reset_bus_q    <= reset_bus_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default parameters).
// Flush expectations follow whether ROB_FLUSH_EN is defined for the build.
module tb_reorder_buffer;

    logic          clk;
    logic          reset;
    logic          alloc_req;
    logic [4:0]    alloc_dest;
    logic          alloc_is_branch;
    logic          alloc_ready;
    logic [3:0]    alloc_index;
    logic [127:0]  data_bus;
    logic [3:0]    valid_bus;
    logic [15:0]   RB_index_bus;
    logic [255:0]  CDB_data_data;
    logic [7:0]    CDB_data_valid;
    logic [3:0]    reset_bus;
    logic          commit_valid;
    logic [4:0]    commit_reg;
    logic [31:0]   commit_data;
    logic          branch_valid;
    logic          branch_taken;
    logic          flush;

    int n_cmp;
    int n_err;

    reorder_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_dest     (alloc_dest),
        .alloc_is_branch(alloc_is_branch),
        .alloc_ready    (alloc_ready),
        .alloc_index    (alloc_index),
        .data_bus       (data_bus),
        .valid_bus      (valid_bus),
        .RB_index_bus   (RB_index_bus),
        .CDB_data_data  (CDB_data_data),
        .CDB_data_valid (CDB_data_valid),
        .reset_bus      (reset_bus),
        .commit_valid   (commit_valid),
        .commit_reg     (commit_reg),
        .commit_data    (commit_data),
        .branch_valid   (branch_valid),
        .branch_taken   (branch_taken),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req       = 1'b0;
        alloc_is_branch = 1'b0;
        alloc_dest      = 5'd0;
        valid_bus       = 4'b0000;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wb(input int f, input logic [3:0] tag, input logic [31:0] d);
        valid_bus[f]           = 1'b1;
        RB_index_bus[f*4 +: 4] = tag;
        data_bus[f*32 +: 32]   = d;
    endtask

    task automatic alloc(input logic [4:0] dest, input logic br);
        alloc_req       = 1'b1;
        alloc_dest      = dest;
        alloc_is_branch = br;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ready got=%0h exp=1", alloc_ready); end
        n_cmp++; if (alloc_index !== 4'd0) begin n_err++; $display("FAIL rst_alloc_index got=%0h exp=0", alloc_index); end
        n_cmp++; if (CDB_data_valid !== 8'h00) begin n_err++; $display("FAIL rst_cdb_valid got=%0h exp=0", CDB_data_valid); end
        n_cmp++; if (CDB_data_data !== 256'd0) begin n_err++; $display("FAIL rst_cdb_data got=%0h exp=0", CDB_data_data); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL rst_commit_valid got=%0h exp=0", commit_valid); end
        n_cmp++; if (commit_reg !== 5'd0) begin n_err++; $display("FAIL rst_commit_reg got=%0h exp=0", commit_reg); end
        n_cmp++; if (commit_data !== 32'd0) begin n_err++; $display("FAIL rst_commit_data got=%0h exp=0", commit_data); end
        n_cmp++; if (branch_valid !== 1'b0) begin n_err++; $display("FAIL rst_branch_valid got=%0h exp=0", branch_valid); end
        n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL rst_branch_taken got=%0h exp=0", branch_taken); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%0h exp=0", flush); end
        n_cmp++; if (reset_bus !== 4'hF) begin n_err++; $display("FAIL rst_reset_bus got=%0h exp=f", reset_bus); end
        reset = 1'b0;
        tick();
        n_cmp++; if (reset_bus !== 4'h0) begin n_err++; $display("FAIL rst_reset_bus_release got=%0h exp=0", reset_bus); end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc(5'd1, 1'b0); tick();
        alloc(5'd2, 1'b0); tick();
        alloc(5'd3, 1'b0); tick();
        idle();
        n_cmp++; if (alloc_index !== 4'd3) begin n_err++; $display("FAIL io_alloc_index got=%0h exp=3", alloc_index); end
        wb(0, 4'd2, 32'h22); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0100) begin n_err++; $display("FAIL io_cdb_valid_e2 got=%0h exp=04", CDB_data_valid); end
        n_cmp++; if (CDB_data_data[2*32 +: 32] !== 32'h22) begin n_err++; $display("FAIL io_cdb_data_e2 got=%0h exp=22", CDB_data_data[2*32 +: 32]); end
        wb(1, 4'd0, 32'h11); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0101) begin n_err++; $display("FAIL io_cdb_valid_e0 got=%0h exp=05", CDB_data_valid); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_commit_early got=%0h exp=0", commit_valid); end
        wb(1, 4'd1, 32'hAA); tick(); idle();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd1 || commit_data !== 32'h11)
            begin n_err++; $display("FAIL io_commit1 got=%0h/%0h/%0h exp=1/1/11", commit_valid, commit_reg, commit_data); end
        n_cmp++; if (CDB_data_valid !== 8'b0000_0110) begin n_err++; $display("FAIL io_cdb_valid_after1 got=%0h exp=06", CDB_data_valid); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd2 || commit_data !== 32'hAA)
            begin n_err++; $display("FAIL io_commit2 got=%0h/%0h/%0h exp=1/2/aa", commit_valid, commit_reg, commit_data); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd3 || commit_data !== 32'h22)
            begin n_err++; $display("FAIL io_commit3 got=%0h/%0h/%0h exp=1/3/22", commit_valid, commit_reg, commit_data); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_commit_idle got=%0h exp=0", commit_valid); end
        n_cmp++; if (CDB_data_valid !== 8'h00) begin n_err++; $display("FAIL io_cdb_empty got=%0h exp=0", CDB_data_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(5'(i + 8), 1'b0);
            tick();
        end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_alloc_ready got=%0h exp=0", alloc_ready); end
        n_cmp++; if (alloc_index !== 4'd0) begin n_err++; $display("FAIL full_alloc_index got=%0h exp=0", alloc_index); end
        alloc(5'd31, 1'b0); tick();
        n_cmp++; if (alloc_index !== 4'd0 || alloc_ready !== 1'b0)
            begin n_err++; $display("FAIL full_ninth_rejected got=%0h/%0h exp=0/0", alloc_index, alloc_ready); end
        idle();
        wb(3, 4'd0, 32'h55); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0001) begin n_err++; $display("FAIL full_cdb_valid got=%0h exp=01", CDB_data_valid); end
        // Commit edge while full: the simultaneous request must not be taken.
        alloc(5'd21, 1'b0); tick();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd8 || commit_data !== 32'h55)
            begin n_err++; $display("FAIL full_commit0 got=%0h/%0h/%0h exp=1/8/55", commit_valid, commit_reg, commit_data); end
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_index !== 4'd0)
            begin n_err++; $display("FAIL full_after_commit got=%0h/%0h exp=1/0", alloc_ready, alloc_index); end
        alloc(5'd22, 1'b0); tick(); idle();
        n_cmp++; if (alloc_index !== 4'd1 || alloc_ready !== 1'b0)
            begin n_err++; $display("FAIL wrap_alloc got=%0h/%0h exp=1/0", alloc_index, alloc_ready); end
    endtask

    task automatic test_collision();
        do_reset();
        alloc(5'd4, 1'b0); tick();
        alloc(5'd5, 1'b0); wb(3, 4'd1, 32'hEE); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'h00) begin n_err++; $display("FAIL col_wb_on_alloc got=%0h exp=0", CDB_data_valid); end
        wb(0, 4'd1, 32'd9); wb(2, 4'd1, 32'd5); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0010) begin n_err++; $display("FAIL col_cdb_valid got=%0h exp=02", CDB_data_valid); end
        n_cmp++; if (CDB_data_data[1*32 +: 32] !== 32'd9) begin n_err++; $display("FAIL col_lowest_fu got=%0h exp=9", CDB_data_data[1*32 +: 32]); end
        wb(1, 4'd1, 32'h77); wb(3, 4'hF, 32'h33); wb(0, 4'd8, 32'h44); tick(); idle();
        n_cmp++; if (CDB_data_data[1*32 +: 32] !== 32'd9) begin n_err++; $display("FAIL col_done_ignored got=%0h exp=9", CDB_data_data[1*32 +: 32]); end
        n_cmp++; if (CDB_data_valid !== 8'b0000_0010) begin n_err++; $display("FAIL col_bad_tags got=%0h exp=02", CDB_data_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc(5'd0, 1'b1); tick();
        alloc(5'd6, 1'b0); tick();
        alloc(5'd7, 1'b0); tick();
        idle();
        wb(0, 4'd0, 32'd1); wb(1, 4'd1, 32'h61); wb(2, 4'd2, 32'h62); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0111) begin n_err++; $display("FAIL fl_cdb_valid got=%0h exp=07", CDB_data_valid); end
        tick();
        n_cmp++; if (branch_valid !== 1'b1 || branch_taken !== 1'b1)
            begin n_err++; $display("FAIL fl_branch got=%0h/%0h exp=1/1", branch_valid, branch_taken); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL fl_branch_no_commit got=%0h exp=0", commit_valid); end
`ifdef ROB_FLUSH_EN
        n_cmp++; if (flush !== 1'b1 || reset_bus !== 4'b1111)
            begin n_err++; $display("FAIL fl_flush_pulse got=%0h/%0h exp=1/f", flush, reset_bus); end
        n_cmp++; if (alloc_index !== 4'd0 || alloc_ready !== 1'b0 || CDB_data_valid !== 8'h00)
            begin n_err++; $display("FAIL fl_cleared got=%0h/%0h/%0h exp=0/0/0", alloc_index, alloc_ready, CDB_data_valid); end
        tick();
        n_cmp++; if (flush !== 1'b0 || reset_bus !== 4'h0 || commit_valid !== 1'b0 || branch_valid !== 1'b0)
            begin n_err++; $display("FAIL fl_after got=%0h/%0h/%0h/%0h exp=0/0/0/0", flush, reset_bus, commit_valid, branch_valid); end
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_index !== 4'd0)
            begin n_err++; $display("FAIL fl_alloc_after got=%0h/%0h exp=1/0", alloc_ready, alloc_index); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_alu_commit got=%0h exp=0", commit_valid); end
`else
        n_cmp++; if (flush !== 1'b0 || reset_bus !== 4'h0)
            begin n_err++; $display("FAIL fl_no_flush got=%0h/%0h exp=0/0", flush, reset_bus); end
        n_cmp++; if (CDB_data_valid !== 8'b0000_0110) begin n_err++; $display("FAIL fl_cdb_kept got=%0h exp=06", CDB_data_valid); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd6 || commit_data !== 32'h61)
            begin n_err++; $display("FAIL fl_alu1 got=%0h/%0h/%0h exp=1/6/61", commit_valid, commit_reg, commit_data); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1 || commit_reg !== 5'd7 || commit_data !== 32'h62)
            begin n_err++; $display("FAIL fl_alu2 got=%0h/%0h/%0h exp=1/7/62", commit_valid, commit_reg, commit_data); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0 || alloc_index !== 4'd3)
            begin n_err++; $display("FAIL fl_end got=%0h/%0h exp=0/3", commit_valid, alloc_index); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            alloc(5'(i), 1'b0);
            tick();
        end
        idle();
        wb(0, 4'd0, 32'h10); tick(); idle();
        n_cmp++; if (CDB_data_valid !== 8'b0000_0001) begin n_err++; $display("FAIL rm_pre got=%0h exp=01", CDB_data_valid); end
        reset = 1'b1;
        alloc(5'd9, 1'b0);
        wb(1, 4'd1, 32'hBB);
        tick();
        idle();
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_index !== 4'd0)
            begin n_err++; $display("FAIL rm_alloc got=%0h/%0h exp=1/0", alloc_ready, alloc_index); end
        n_cmp++; if (CDB_data_valid !== 8'h00 || CDB_data_data !== 256'd0)
            begin n_err++; $display("FAIL rm_cdb got=%0h/%0h exp=0/0", CDB_data_valid, CDB_data_data); end
        n_cmp++; if (commit_valid !== 1'b0 || commit_reg !== 5'd0 || commit_data !== 32'd0)
            begin n_err++; $display("FAIL rm_commit got=%0h/%0h/%0h exp=0/0/0", commit_valid, commit_reg, commit_data); end
        n_cmp++; if (branch_valid !== 1'b0 || flush !== 1'b0 || reset_bus !== 4'hF)
            begin n_err++; $display("FAIL rm_misc got=%0h/%0h/%0h exp=0/0/f", branch_valid, flush, reset_bus); end
        reset = 1'b0;
        tick();
        n_cmp++; if (reset_bus !== 4'h0 || commit_valid !== 1'b0 || CDB_data_valid !== 8'h00)
            begin n_err++; $display("FAIL rm_release got=%0h/%0h/%0h exp=0/0/0", reset_bus, commit_valid, CDB_data_valid); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0 || alloc_index !== 4'd0)
            begin n_err++; $display("FAIL rm_quiet got=%0h/%0h exp=0/0", commit_valid, alloc_index); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        data_bus     = 128'd0;
        RB_index_bus = 16'd0;
        idle();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_collision();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo core. It allocates entries to the issue stage and captures results that the reservation stations broadcast on `data_bus`/`valid_bus`/`RB_index_bus`. It republishes completed values to every station on `CDB_data_data`/`CDB_data_valid` and commits in program order to the register file. On a taken branch it flushes all entries and pulses `reset_bus` to clear every functional unit.

## Interface
- `WORD_SIZE`, 32, data width
- `RB_SIZE`, 8, number of entries
- `RB_INDEX`, 4, entry-index width; must satisfy `RB_SIZE < 2**RB_INDEX`
- `NULL`, `{RB_INDEX{1'b1}}`, "no destination" tag
- `FU_NUM`, 4, number of functional units on the result buses
- `REG_INDEX`, 5, architectural register-number width
- `clk` in 1: the single clock; everything samples on posedge.
- `reset` in 1: synchronous, active-high.
- `alloc_req` in 1: issue stage requests an entry.
- `alloc_dest` in REG_INDEX: destination register of the issuing instruction.
- `alloc_is_branch` in 1: the issuing instruction is a branch.
- `alloc_ready` out 1: an entry is available this cycle.
- `alloc_index` out RB_INDEX: index the request will receive; equals tail.
- `data_bus` in FU_NUM*WORD_SIZE: per-FU result; FU f occupies slice `[(f+1)*WORD_SIZE-1 : f*WORD_SIZE]`.
- `valid_bus` in FU_NUM: per-FU result valid.
- `RB_index_bus` in FU_NUM*RB_INDEX: per-FU destination entry.
- `CDB_data_data` out WORD_SIZE*RB_SIZE: per-entry value; entry i occupies slice i.
- `CDB_data_valid` out RB_SIZE: entry i is busy and done.
- `reset_bus` out FU_NUM: per-FU clear.
- `commit_valid` out 1: register write strobe.
- `commit_reg` out REG_INDEX: register number for the write.
- `commit_data` out WORD_SIZE: data for the write.
- `branch_valid` out 1: a branch retired this cycle.
- `branch_taken` out 1: outcome of the retired branch.
- `flush` out 1: pipeline flush pulse.

## Operation
- Per-entry state: busy, done, is_branch, dest, value. Pointers head and tail; count ranges 0..RB_SIZE.
- **Allocate:** `alloc_ready = (count < RB_SIZE) && !flush`.
  - On `alloc_req && alloc_ready`, the entry at tail becomes busy=1, done=0, with dest and is_branch loaded from the request.
  - tail increments, wrapping from RB_SIZE-1 to 0.
- **Writeback:** each edge, for each f with `valid_bus[f]=1`:
  - The tag t is taken from `RB_index_bus` slice f.
  - If `t != NULL`, `t < RB_SIZE`, and entry t is busy and not done, then value gets the `data_bus` slice f and done is set to 1.
  - If several FUs name the same entry, the lowest f wins.
  - All other tags are ignored.
- **Broadcast:** `CDB_data_valid[i]` is the registered busy[i]&done[i]. The `CDB_data_data` slice i is the registered value[i].
- **Commit:** at most one retirement per edge, and only when the head entry is busy and done.
  - The entry is cleared and head wraps forward.
  - A non-branch entry pulses `commit_valid` for one cycle with `commit_reg` = dest and `commit_data` = value.
  - A branch entry pulses `branch_valid` for one cycle with `branch_taken` = value[0]. `commit_valid` stays 0.
- **Count update:** count changes by +alloc −commit. Full with a simultaneous commit still blocks the allocation.
- **Flush:** applies when a committed branch has value[0]=1 (see Configuration).
  - On that same edge, all busy/done bits clear and head = tail = count = 0.
  - Allocation, writeback, and commit of other entries on that edge are discarded.
  - During the following cycle, `flush` = 1 and `reset_bus` = all ones.
- **Reset values:** `alloc_ready`=1 after reset, `alloc_index`=0, `CDB_data_valid`=0, `CDB_data_data`=0, `commit_*`=0, `branch_*`=0, `flush`=0, `reset_bus`=all ones. Pointers and count are 0. `reset_bus` returns to 0 on the first edge with reset low.

## Timing
- Result latency: a result sampled at edge N is visible on `CDB_data_valid` during cycle N+1.
- Commit latency: the earliest commit decision for that entry is at edge N+1, so `commit_valid` is high during cycle N+2.
- A writeback to the head entry at edge N cannot commit at edge N, because commit uses registered done.
- A writeback naming the entry being allocated on the same edge is ignored, because the entry is not yet busy.
- `alloc_ready` and `alloc_index` are combinational from registered state; a request is accepted at the edge where both `alloc_req` and `alloc_ready` are 1.
- Reset mid-operation wins over every other event at that edge.

## Configuration
- `ROB_FLUSH_EN` defined: a retired branch with `branch_taken`=1 triggers a flush as described above.
- `ROB_FLUSH_EN` undefined: branches retire and report `branch_valid`/`branch_taken` only. `flush` is tied to 0, and `reset_bus` is asserted only by `reset`.

## Test plan
- **In-order commit:** reset, then allocate 3 entries (regs 1, 2, 3). FU0 writes entry 2 = 0x22, then FU1 writes entry 0 = 0x11, then entry 1 = 0xAA.
  - `CDB_data_valid` follows each write by one cycle.
  - Commits come out in order 1→0x11, 2→0xAA, 3→0x22 on consecutive cycles.
- **Full and wrap-around:** allocate 8 entries; `alloc_ready`=0 and a ninth request is not accepted.
  - Complete and retire entry 0; the next allocation receives index 0 while tail wraps.
- **Same-tag collision:** FU2 and FU0 both target entry 1 on the same edge, with 5 and 9.
  - Entry value = 9.
  - A second write to the now-done entry is ignored.
- **Flush:** with `ROB_FLUSH_EN` defined, allocate a branch followed by 2 ALU entries.
  - The branch result is 1 and both ALU entries complete.
  - Branch retires with `branch_taken`=1; next cycle `flush`=1 and `reset_bus`=4'b1111; the ALU entries never commit; `alloc_index`=0.
  - With the macro undefined: `flush` stays 0 and both ALU entries commit.
- **Reset mid-operation:** assert `reset` with 4 busy entries and a concurrent writeback.
  - All outputs return to reset values; `CDB_data_valid`=0; `alloc_ready`=1.
